// File: rtl/motor_cmd_shaper.sv
// motor_cmd_shaper: turns signed left/right speed commands into 11-bit duty
// magnitudes plus direction bits for the PWM stages. Each side is
// slew-limited and saturated, and holds a zero-duty dwell before it reverses.
// Values are released once per PWM period, on the period-counter wrap.
// Enable-low and over-current force both sides to zero within one clock.

// One motor side: IDLE / RUN / DWELL state machine plus the duty datapath.
module motor_cmd_side #(
  parameter int unsigned SLEW  = 16,
  parameter int unsigned DWELL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_evt,
  input  logic        force_idle,
  input  logic [11:0] spd,
  output logic [10:0] duty,
  output logic        rev
);

  localparam int unsigned   CW      = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  localparam logic [11:0]   SLEW_W  = SLEW[11:0];
  localparam logic [CW-1:0] DWELL_W = DWELL[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DWELL
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   mag_q, mag_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [11:0]   neg_spd;
  logic [10:0]   tgt_mag;
  logic          tgt_dir;
  logic [11:0]   mag12;
  logic [11:0]   tgt12;
  logic [11:0]   up12;
  logic [11:0]   dn12;

  // Target magnitude/direction. A zero target keeps the present direction.
  // -2048 has no positive 12-bit counterpart and saturates to 2047.
  always_comb begin
    neg_spd = ~spd + 12'd1;
    if (!spd[11]) begin
      tgt_mag = spd[10:0];
    end else if (neg_spd[11]) begin
      tgt_mag = '1;
    end else begin
      tgt_mag = neg_spd[10:0];
    end
    tgt_dir = (tgt_mag == '0) ? dir_q : spd[11];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-duty logic. Forced idle wins over any update; slew
  // arithmetic is carried in 12 bits so mag + SLEW cannot wrap past 2047.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    mag12   = {1'b0, mag_q};
    tgt12   = {1'b0, tgt_mag};
    up12    = mag12 + SLEW_W;
    dn12    = mag12 - SLEW_W;
    if (force_idle) begin
      state_d = S_IDLE;
      mag_d   = '0;
    end else if (upd_evt) begin
      unique case (state_q)
        S_IDLE: begin
          dir_d   = tgt_dir;
          mag_d   = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (tgt_dir == dir_q) begin
            if (tgt12 > mag12) begin
              mag_d = (up12 > tgt12) ? tgt_mag : up12[10:0];
            end else if ((mag12 - tgt12) > SLEW_W) begin
              mag_d = dn12[10:0];
            end else begin
              mag_d = tgt_mag;
            end
          end else if (mag_q != '0) begin
            mag_d = (mag12 > SLEW_W) ? dn12[10:0] : '0;
          end else begin
            state_d = S_DWELL;
            cnt_d   = DWELL_W;
          end
        end
        S_DWELL: begin
          mag_d = '0;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            dir_d   = tgt_dir;
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          mag_d   = '0;
        end
      endcase
    end
  end

  // Outputs come straight from the registered magnitude and direction.
  always_comb begin
    duty = mag_q;
    rev  = dir_q;
  end

endmodule

// Top: shared period counter, update pulse, fault latch and both sides.
module motor_cmd_shaper #(
  parameter int unsigned SLEW  = 16,
  parameter int unsigned DWELL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ovr_i,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic [10:0] lft_duty,
  output logic        lft_rev,
  output logic [10:0] rght_duty,
  output logic        rght_rev,
  output logic        upd,
  output logic        fault
);

  logic [10:0] pc;
  logic        upd_q;
  logic        fault_q;
  logic        upd_evt;
  logic        force_idle;

  // Update event on the last count of the period; forced idle is combined
  // from the live ovr_i so the shutdown lands on the same edge as the latch.
  always_comb begin
    upd_evt    = (pc == '1);
    force_idle = ~en | ovr_i | fault_q;
  end

  // Free-running period counter, update pulse and sticky over-current flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      upd_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc      <= pc + 11'd1;
      upd_q   <= upd_evt;
      fault_q <= fault_q | ovr_i;
    end
  end

  motor_cmd_side #(.SLEW(SLEW), .DWELL(DWELL)) u_lft (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_evt    (upd_evt),
    .force_idle (force_idle),
    .spd        (lft_spd),
    .duty       (lft_duty),
    .rev        (lft_rev)
  );

  motor_cmd_side #(.SLEW(SLEW), .DWELL(DWELL)) u_rght (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_evt    (upd_evt),
    .force_idle (force_idle),
    .spd        (rght_spd),
    .duty       (rght_duty),
    .rev        (rght_rev)
  );

  // Status outputs.
  always_comb begin
    upd   = upd_q;
    fault = fault_q;
  end

endmodule

// File: doc/motor_cmd_shaper.md
# motor_cmd_shaper

Conditions signed left/right speed commands from the balance controller into per-motor 11-bit duty magnitudes and direction bits for the downstream 11-bit PWM stages (one forward/reverse PWM pair per motor). It applies slew-rate limiting, saturation, a zero-dwell on direction reversal, enable gating and a latched over-current shutdown. New values are released once per PWM period, aligned to the PWM counter wrap, so a PWM period never sees a mid-period duty change.

## Interface
- SLEW, default 16: maximum change in duty magnitude per update.
- DWELL, default 2: number of updates held at duty 0 before a direction flip.
- clk  input  1  50 MHz system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  motor enable; low forces both duties to 0.
- ovr_i  input  1  over-current indication, synchronous to clk.
- lft_spd  input  12  signed left speed command, two's complement.
- rght_spd  input  12  signed right speed command, two's complement.
- lft_duty  output  11  left duty magnitude to the PWM stage.
- lft_rev  output  1  left direction; 1 = reverse.
- rght_duty  output  11  right duty magnitude.
- rght_rev  output  1  right direction.
- upd  output  1  one-cycle pulse marking that new duty values took effect.
- fault  output  1  latched over-current flag.

## Operation
- Internal free-running 11-bit period counter pc, reset to 0 together with the PWM stages, so it stays aligned with their counters. The update event is pc == 2047.
- Target per side: magnitude = |spd|, saturated to 2047 (-2048 maps to 2047). Target direction = spd[11]. When the target magnitude is 0, the target direction is "don't care" and the current direction is kept.
- Each side runs an independent FSM with states IDLE, RUN and DWELL. The two sides share pc, en and fault only.
- IDLE: mag = 0. On an update with en=1 and fault=0: dir <= target direction, go to RUN. mag stays 0 for this update.
- RUN, on an update:
  - Target direction equals dir, or target magnitude is 0: mag moves toward the target by at most SLEW, with no overshoot. The clamp is computed in 12 bits so it never wraps.
  - Target direction is opposite and mag > 0: mag moves toward 0 by at most SLEW.
  - Target direction is opposite and mag == 0: go to DWELL and load the dwell count with DWELL.
- DWELL: mag = 0. Each update decrements the dwell count. On the update where the count reaches 0, dir <= the current target direction and the FSM returns to RUN with mag still 0. If the target returns to the original direction during dwell, the dwell still completes.
- Duty outputs equal the registered mag. rev outputs equal the registered dir.
- en low, checked every cycle, not only at updates: both FSMs go to IDLE and both mag values go to 0 on the next clk edge. dir is held.
- ovr_i high on any cycle: fault <= 1 and both FSMs go to IDLE with mag = 0 on the next edge. fault clears only on rst_n. While fault=1 the FSMs stay in IDLE regardless of en.
- Command inputs are sampled only at updates. Changes between updates are ignored.

## Timing
- Reset values: lft_duty = rght_duty = 0, lft_rev = rght_rev = 0, upd = 0, fault = 0, both FSMs in IDLE, pc = 0.
- Normal duty and rev changes occur only on the edge where pc goes 2047 to 0. The new value is therefore present when the PWM counter is 0 and is latched for the whole period.
- upd is high for exactly the one cycle after that edge (pc == 0), every period, even if no value changed.
- First update after reset happens at cycle 2047 after rst_n deassertion.
- Forced zero from en low or ovr_i takes 1 clk of latency, independent of pc. upd is not pulsed for a forced zero.
- Asynchronous reset mid-period: all state is cleared immediately and pc restarts from 0.

## Test plan
- Ramp-up (SLEW=16): en=1, lft_spd=+100. Required sequence: update 1 = RUN with duty 0; updates 2–7 = duty 16, 32 … 96; update 8 = duty 100, lft_rev = 0. rght_duty stays 0 throughout.
- Saturation: rght_spd = -2048, held until steady state. Required: rght_rev = 1 and rght_duty ramps to exactly 2047, never 0 and never a wrapped value.
- Reversal (DWELL=2): steady lft_duty = 32, rev = 0, then command -32. Required duty per update: 16, 0, then DWELL for 2 updates at 0. lft_rev = 1 appears at the dwell exit. Duty then rises 16, 32.
- Enable drop: deassert en mid-ramp at pc = 500. Required: both duties are 0 at pc = 501, without waiting for an update. After re-enabling, the FSM restarts from IDLE.
- Fault: one-cycle ovr_i pulse. Required: fault = 1 and both duties 0 on the next edge. Both stay so with en = 1 and ovr_i = 0 for 5 periods, and clear only after rst_n.
- Mid-period command change: change lft_spd at pc = 1000. Required: no output change before pc wraps. Separately, check that upd pulses once per 2048 cycles.
